// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter between the
// CPU memory stage and the host image burst port.
package mem_arb_pkg;

    localparam int DEF_AW       = 32;
    localparam int DEF_DW       = 128;
    localparam int DEF_LW       = 8;
    localparam int DEF_MAX_WAIT = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOST_WR = 2'd1,
        ST_HOST_RD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/burst_addr_gen.sv
// Beat address and beat counter for one host burst; the address wraps
// modulo 2^AW and last_beat flags the final beat of the loaded length.
module burst_addr_gen #(
    parameter int AW = 32,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] len,
    input  logic          step,
    output logic [AW-1:0] beat_addr,
    output logic          last_beat
);

    logic [AW-1:0] addr_reg;
    logic [LW-1:0] len_reg;
    logic [LW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg <= '0;
            len_reg  <= '0;
            cnt_reg  <= '0;
        end else if (load) begin
            addr_reg <= base_addr;
            len_reg  <= len;
            cnt_reg  <= '0;
        end else if (step) begin
            addr_reg <= addr_reg + AW'(1);
            cnt_reg  <= cnt_reg + LW'(1);
        end
    end

    assign beat_addr = addr_reg;
    assign last_beat = (cnt_reg == len_reg);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port data memory between the CPU memory stage
// (priority) and host image bursts, with a bounded wait for the host.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int LW       = DEF_LW,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_rmem,
    input  logic          cpu_wmem,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [LW-1:0] host_len,
    output logic          host_busy,
    input  logic          host_wvalid,
    input  logic [DW-1:0] host_wdata,
    output logic          host_wready,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          host_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    arb_state_t     state_reg, state_next;
    logic           pending_reg;
    logic           busy_reg;
    logic           we_reg;
    logic [WCW-1:0] wait_cnt_reg;
    logic           rvalid_reg;
    logic           rdone_reg;

    logic           cpu_acc;
    logic           req_acc;
    logic           pend;
    logic           req_we;
    logic           grant;
    logic           step;
    logic           wr_done;
    logic [AW-1:0]  beat_addr;
    logic           last_beat;

    assign cpu_acc = cpu_rmem | cpu_wmem;
    assign req_acc = host_req & ~busy_reg;
    // A request arriving this cycle already counts as pending, so an idle
    // CPU lets the burst start on the very next edge.
    assign pend    = pending_reg | req_acc;
    assign req_we  = pending_reg ? we_reg : host_we;

    burst_addr_gen #(
        .AW(AW),
        .LW(LW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (req_acc),
        .base_addr (host_addr),
        .len       (host_len),
        .step      (step),
        .beat_addr (beat_addr),
        .last_beat (last_beat)
    );

    always_comb begin
        state_next  = state_reg;
        grant       = 1'b0;
        step        = 1'b0;
        wr_done     = 1'b0;
        cpu_stall   = 1'b0;
        host_wready = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = cpu_addr;
        mem_wdata   = cpu_wdata;
        case (state_reg)
            ST_IDLE: begin
                mem_en = cpu_acc;
                mem_we = cpu_wmem;
                if (pend && (!cpu_acc || wait_cnt_reg == WCW'(MAX_WAIT))) begin
                    grant      = 1'b1;
                    state_next = req_we ? ST_HOST_WR : ST_HOST_RD;
                end
            end
            ST_HOST_WR: begin
                cpu_stall   = cpu_acc;
                host_wready = 1'b1;
                mem_addr    = beat_addr;
                mem_wdata   = host_wdata;
                mem_en      = host_wvalid;
                mem_we      = host_wvalid;
                if (host_wvalid) begin
                    step = 1'b1;
                    if (last_beat) begin
                        wr_done    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_HOST_RD: begin
                cpu_stall = cpu_acc;
                mem_addr  = beat_addr;
                mem_en    = 1'b1;
                step      = 1'b1;
                if (last_beat) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            pending_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            we_reg       <= 1'b0;
            wait_cnt_reg <= '0;
            rvalid_reg   <= 1'b0;
            rdone_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pend & ~grant;
            if (req_acc) begin
                we_reg <= host_we;
            end
            // Read bursts stay busy until the trailing data beat has gone out.
            if (req_acc) begin
                busy_reg <= 1'b1;
            end else if (wr_done || rdone_reg) begin
                busy_reg <= 1'b0;
            end
            if (grant) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == ST_IDLE && pend && cpu_acc &&
                         wait_cnt_reg != WCW'(MAX_WAIT)) begin
                wait_cnt_reg <= wait_cnt_reg + WCW'(1);
            end
            rvalid_reg <= (state_reg == ST_HOST_RD);
            rdone_reg  <= (state_reg == ST_HOST_RD) && last_beat;
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign host_busy  = busy_reg;
    assign host_rvalid = rvalid_reg;
    assign host_rdata = rvalid_reg ? mem_rdata : '0;
    assign host_done  = wr_done | rdone_reg;

endmodule
